// File: rtl/invaders_march_ctrl.sv
// Invader formation march sequencer: paces ticks, steps the formation sideways and drops rows.
// Optional macro INVADERS_MARCH_SPEEDUP_EN makes the march period track the number of living invaders.
module invaders_march_ctrl #(
    parameter int ARRAY_W     = 20,
    parameter int FIELD_W     = 32,
    parameter int START_ROW   = 1,
    parameter int LAND_ROW    = 15,
    parameter int MIN_PERIOD  = 900000,
    parameter int STEP_PERIOD = 450000
) (
    input  logic               i_clk_36MHz,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic [ARRAY_W-1:0] i_invaders_array,
    output logic signed [5:0]  o_col_offset,
    output logic [3:0]         o_invaders_row,
    output logic               o_direction,
    output logic               o_step,
    output logic               o_drop,
    output logic               o_landed,
    output logic               o_cleared,
    output logic [31:0]        o_period,
    output logic [1:0]         o_dbg_state
);

    localparam int IDX_W = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1;
    localparam logic [31:0] RESET_PERIOD = 32'(MIN_PERIOD + ARRAY_W * STEP_PERIOD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARCH   = 2'd1,
        LANDED  = 2'd2,
        CLEARED = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic signed [5:0]  offset_q, offset_d;
    logic [3:0]         row_q, row_d;
    logic               dir_q, dir_d;
    logic               step_q, step_d;
    logic               drop_q, drop_d;
    logic               landed_q, landed_d;
    logic               cleared_q, cleared_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        period_q, period_d;

    logic [IDX_W-1:0]   lo_idx, hi_idx;
    logic [7:0]         left_pos, right_pos;
    logic               mask_empty;
    logic               at_edge;
    logic               tick;
    logic [31:0]        period_calc;

    // Lowest and highest living slot bound the formation's screen extent.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        for (int i = ARRAY_W - 1; i >= 0; i--) begin
            if (i_invaders_array[i]) lo_idx = IDX_W'(i);
        end
        for (int i = 0; i < ARRAY_W; i++) begin
            if (i_invaders_array[i]) hi_idx = IDX_W'(i);
        end
    end

    assign left_pos   = {{2{offset_q[5]}}, offset_q} + 8'(lo_idx);
    assign right_pos  = {{2{offset_q[5]}}, offset_q} + 8'(hi_idx);
    assign mask_empty = (i_invaders_array == '0);
    assign at_edge    = dir_q ? (left_pos == 8'd0) : (right_pos == 8'(FIELD_W - 1));
    assign tick       = (state_q == MARCH) && !i_start && !i_pause && (cnt_q >= period_q - 32'd1);

`ifdef INVADERS_MARCH_SPEEDUP_EN
    logic [31:0] alive_cnt;

    always_comb begin
        alive_cnt = '0;
        for (int i = 0; i < ARRAY_W; i++) begin
            alive_cnt = alive_cnt + 32'(i_invaders_array[i]);
        end
        period_calc = 32'(MIN_PERIOD) + alive_cnt * 32'(STEP_PERIOD);
    end
`else
    assign period_calc = RESET_PERIOD;
`endif

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        row_d     = row_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        drop_d    = 1'b0;
        landed_d  = landed_q;
        cleared_d = cleared_q;
        cnt_d     = cnt_q;
        period_d  = period_q;

        if (i_start) begin
            state_d   = MARCH;
            offset_d  = '0;
            row_d     = 4'(START_ROW);
            dir_d     = 1'b0;
            cnt_d     = '0;
            landed_d  = 1'b0;
            cleared_d = 1'b0;
            period_d  = period_calc;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d    = '0;
                    period_d = period_calc;
                end
                MARCH: begin
                    period_d = period_calc;
                    if (tick) begin
                        cnt_d = '0;
                        if (mask_empty) begin
                            state_d   = CLEARED;
                            cleared_d = 1'b1;
                        end else if (at_edge) begin
                            row_d  = row_q + 4'd1;
                            dir_d  = ~dir_q;
                            drop_d = 1'b1;
                            if (row_q + 4'd1 == 4'(LAND_ROW)) begin
                                state_d  = LANDED;
                                landed_d = 1'b1;
                            end
                        end else begin
                            offset_d = dir_q ? (offset_q - 6'sd1) : (offset_q + 6'sd1);
                            step_d   = 1'b1;
                        end
                    end else if (!i_pause) begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk_36MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            offset_q  <= '0;
            row_q     <= 4'(START_ROW);
            dir_q     <= 1'b0;
            step_q    <= 1'b0;
            drop_q    <= 1'b0;
            landed_q  <= 1'b0;
            cleared_q <= 1'b0;
            cnt_q     <= '0;
            period_q  <= RESET_PERIOD;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            row_q     <= row_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            drop_q    <= drop_d;
            landed_q  <= landed_d;
            cleared_q <= cleared_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
        end
    end

`ifndef SYNTHESIS
    // The formation must stay on the playfield whenever a tick evaluates it.
    always_ff @(posedge i_clk_36MHz) begin
        if (i_reset_n && tick && !mask_empty) begin
            assert ($signed(left_pos) >= 0);
            assert ($signed(right_pos) <= FIELD_W - 1);
        end
    end
`endif

    assign o_col_offset   = offset_q;
    assign o_invaders_row = row_q;
    assign o_direction    = dir_q;
    assign o_step         = step_q;
    assign o_drop         = drop_q;
    assign o_landed       = landed_q;
    assign o_cleared      = cleared_q;
    assign o_period       = period_q;
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_invaders_march_ctrl.sv
// Directed bench for invaders_march_ctrl: a tick-by-tick vector table plus hand-written
// sequences for latency, clear, pause, reset, period and landing.
module tb_invaders_march_ctrl;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MARCH   = 2'd1;
  localparam logic [1:0] ST_LANDED  = 2'd2;
  localparam logic [1:0] ST_CLEARED = 2'd3;
  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [19:0] mask = '0;

  logic signed [5:0] col;
  logic [3:0]  row;
  logic        dir;
  logic        step;
  logic        drop;
  logic        landed;
  logic        cleared;
  logic [31:0] period;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [19:0] mask;
    logic        step;
    logic        drop;
    int          off;
    int          row;
    logic        dir;
  } vec_t;

  vec_t vecs[$];

  invaders_march_ctrl #(
    .ARRAY_W(20),
    .FIELD_W(32),
    .START_ROW(1),
    .LAND_ROW(15),
    .MIN_PERIOD(4),
    .STEP_PERIOD(1)
  ) dut (
    .i_clk_36MHz(clk),
    .i_reset_n(rst_n),
    .i_start(start),
    .i_pause(pause),
    .i_invaders_array(mask),
    .o_col_offset(col),
    .o_invaders_row(row),
    .o_direction(dir),
    .o_step(step),
    .o_drop(drop),
    .o_landed(landed),
    .o_cleared(cleared),
    .o_period(period),
    .o_dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic int exp_period(input logic [19:0] m);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 20; i++) cnt += int'(m[i]);
`ifdef INVADERS_MARCH_SPEEDUP_EN
    return 4 + cnt;
`else
    return (cnt >= 0) ? 24 : 24;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [19:0] m, input logic s, input logic d,
                         input int off, input int r, input logic dr);
    vec_t v;
    v.mask = m; v.step = s; v.drop = d; v.off = off; v.row = r; v.dir = dr;
    vecs.push_back(v);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of cycles until a strobe; BUDGET+1 means it never came.
  task automatic wait_strobe(input string name, output int n);
    int i;
    for (i = 1; i <= BUDGET; i++) begin
      @(negedge clk);
      if (step || drop) break;
    end
    n = i;
    if (i > BUDGET) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n;
    int seen;
    int steps;
    int drops;

    for (int i = 2; i <= 12; i++) add_vec(20'hFFFFF, 1'b1, 1'b0, i, 1, 1'b0);
    add_vec(20'hFFFFF, 1'b0, 1'b1, 12, 2, 1'b1);
    for (int i = 11; i >= 0; i--) add_vec(20'h000FF, 1'b1, 1'b0, i, 2, 1'b1);
    add_vec(20'h000FF, 1'b0, 1'b1, 0, 3, 1'b0);
    for (int i = 1; i <= 12; i++) add_vec(20'hFF000, 1'b1, 1'b0, i, 3, 1'b0);
    add_vec(20'hFF000, 1'b0, 1'b1, 12, 4, 1'b1);
    for (int i = 11; i >= -12; i--) add_vec(20'hFF000, 1'b1, 1'b0, i, 4, 1'b1);
    add_vec(20'hFF000, 1'b0, 1'b1, -12, 5, 1'b0);

    // reset values
    repeat (3) @(negedge clk);
    check("rst_col", int'(col), 0);
    check("rst_row", int'(row), 1);
    check("rst_dir", int'(dir), 0);
    check("rst_step", int'(step), 0);
    check("rst_drop", int'(drop), 0);
    check("rst_landed", int'(landed), 0);
    check("rst_cleared", int'(cleared), 0);
    check("rst_period", int'(period), 24);
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // first step latency with a full formation
    mask = 20'hFFFFF;
    @(negedge clk);
    pulse_start();
    check("start_state", int'(dbg_state), int'(ST_MARCH));
    check("start_col", int'(col), 0);
    wait_strobe("first_step", n);
    check("first_step_latency", n, exp_period(20'hFFFFF));
    check("first_step_pulse", int'(step), 1);
    check("first_step_col", int'(col), 1);
    @(negedge clk);
    check("step_one_cycle", int'(step), 0);

    // tick-by-tick table: right edge, left edge at col 0, left edge at col -12
    foreach (vecs[i]) begin
      mask = vecs[i].mask;
      wait_strobe($sformatf("vec%0d", i), n);
      check($sformatf("vec%0d_step", i), int'(step), int'(vecs[i].step));
      check($sformatf("vec%0d_drop", i), int'(drop), int'(vecs[i].drop));
      check($sformatf("vec%0d_col", i), int'(col), vecs[i].off);
      check($sformatf("vec%0d_row", i), int'(row), vecs[i].row);
      check($sformatf("vec%0d_dir", i), int'(dir), int'(vecs[i].dir));
    end

    // mask emptied mid-period
    repeat (5) @(negedge clk);
    mask = '0;
    seen = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (step || drop) seen = 1;
      if (cleared) break;
    end
    check("clr_flag", int'(cleared), 1);
    check("clr_state", int'(dbg_state), int'(ST_CLEARED));
    check("clr_no_strobe", seen, 0);
    check("clr_col", int'(col), -12);
    check("clr_row", int'(row), 5);
    repeat (30) begin
      @(negedge clk);
      if (step || drop || !cleared || col != -6'sd12) seen = 1;
    end
    check("clr_static", seen, 0);

    // restart from CLEARED
    mask = 20'hFFFFF;
    pulse_start();
    check("restart_col", int'(col), 0);
    check("restart_row", int'(row), 1);
    check("restart_dir", int'(dir), 0);
    check("restart_cleared", int'(cleared), 0);
    check("restart_state", int'(dbg_state), int'(ST_MARCH));

    // pause freezes the counter
    wait_strobe("pre_pause", n);
    check("pre_pause_col", int'(col), 1);
    repeat (5) @(negedge clk);
    pause = 1'b1;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (step || drop) seen = 1;
    end
    check("pause_no_strobe", seen, 0);
    check("pause_col", int'(col), 1);
    pause = 1'b0;
    wait_strobe("post_pause", n);
    check("pause_resume_latency", n, exp_period(20'hFFFFF) - 5);
    check("post_pause_col", int'(col), 2);

    // asynchronous reset mid-count
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_col", int'(col), 0);
    check("arst_row", int'(row), 1);
    check("arst_state", int'(dbg_state), int'(ST_IDLE));
    check("arst_step", int'(step), 0);
    check("arst_period", int'(period), 24);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (step || drop) seen = 1;
    end
    check("idle_no_strobe", seen, 0);
    check("idle_state", int'(dbg_state), int'(ST_IDLE));

    // single survivor sets the period
    mask = 20'h00001;
    repeat (2) @(negedge clk);
    check("single_period", int'(period), exp_period(20'h00001));
    pulse_start();
    wait_strobe("single_step", n);
    check("single_latency", n, exp_period(20'h00001));
    check("single_col", int'(col), 1);

    // march until landing
    mask = 20'hFFFFF;
    pulse_start();
    steps = 0;
    drops = 0;
    for (int k = 0; k < 200; k++) begin
      wait_strobe("land", n);
      if (n > BUDGET) break;
      if (step) steps++;
      if (drop) drops++;
      if (landed) break;
    end
    check("land_drops", drops, 14);
    check("land_steps", steps, 168);
    check("land_flag", int'(landed), 1);
    check("land_row", int'(row), 15);
    check("land_state", int'(dbg_state), int'(ST_LANDED));
    check("land_col", int'(col), 0);
    check("land_dir", int'(dir), 0);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (step || drop || !landed || row != 4'd15) seen = 1;
    end
    check("land_static", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
